// File: rtl/riscv_pkg.sv
// RV32I decode definitions shared by the decode stage, its ID/EX bus and the regfile.
// Contents: opcode constants, ALU operation enum, result-source codes, immediate
// format enum and the funct3/funct7 to ALU-op mapping.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // funct7[5] only distinguishes SUB (register form only) and SRA (both forms).
    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3,
                                               input logic       funct7_b5,
                                               input logic       is_reg);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// ID/EX pipeline bus between the decode stage (master) and execute stage (slave).
// Signals: rd1/rd2 operands, imm, pc/pc4, rs1/rs2/rd indices, and the execute/
// memory/writeback control bits (regwrite, resultsrc, memwrite, branch, jump,
// jalr, alusrca, alusrcb, alucontrol, funct3).
interface decode_stage_if
    import riscv_pkg::*;
#(
    parameter int P_DATA_WIDTH = 32,
    parameter int PC_WIDTH     = 9
);
    logic [P_DATA_WIDTH-1:0] rd1;
    logic [P_DATA_WIDTH-1:0] rd2;
    logic [P_DATA_WIDTH-1:0] imm;
    logic [PC_WIDTH:0]       pc;
    logic [PC_WIDTH:0]       pc4;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
    logic                    regwrite;
    logic [1:0]              resultsrc;
    logic                    memwrite;
    logic                    branch;
    logic                    jump;
    logic                    jalr;
    logic                    alusrca;
    logic                    alusrcb;
    alu_op_e                 alucontrol;
    logic [2:0]              funct3;

    modport master (
        output rd1, rd2, imm, pc, pc4, rs1, rs2, rd, regwrite, resultsrc, memwrite,
               branch, jump, jalr, alusrca, alusrcb, alucontrol, funct3
    );

    modport slave (
        input rd1, rd2, imm, pc, pc4, rs1, rs2, rd, regwrite, resultsrc, memwrite,
              branch, jump, jalr, alusrca, alusrcb, alucontrol, funct3
    );
endinterface

// File: rtl/decode_stage_regfile.sv
// 32 x P_DATA_WIDTH register file: two asynchronous read ports, one write port.
// Ports: i_clk, i_rst_n (async, active-low, clears all registers), ra1/ra2 read
// addresses, rd1/rd2 read data, we/wa/wd write enable/address/data.
// x0 is not stored; it always reads zero and writes to it are dropped.
module decode_stage_regfile #(
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [4:0]              ra1,
    input  logic [4:0]              ra2,
    output logic [P_DATA_WIDTH-1:0] rd1,
    output logic [P_DATA_WIDTH-1:0] rd2,
    input  logic                    we,
    input  logic [4:0]              wa,
    input  logic [P_DATA_WIDTH-1:0] wd
);

    logic [P_DATA_WIDTH-1:0] regs [1:31];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    // Write-through: a same-cycle WB write to the read address is forwarded so
    // the ID/EX register captures the value being written this edge.
    always_comb begin
        if (ra1 == 5'd0)                rd1 = '0;
        else if (we && (wa == ra1))     rd1 = wd;
        else                            rd1 = regs[ra1];
    end

    always_comb begin
        if (ra2 == 5'd0)                rd2 = '0;
        else if (we && (wa == ra2))     rd2 = wd;
        else                            rd2 = regs[ra2];
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the IF/ID instruction, reads the register file
// (written from WB), builds the immediate and loads the ID/EX register.
// Ports: i_clk, i_rst_n (async, active-low), i_flush_e (bubble into ID/EX),
// i_instr_d/i_pc_d/i_pc4_d from IF/ID, i_regwrite_w/i_rd_w/i_result_w from WB,
// o_rs1_d/o_rs2_d combinational source indices for the hazard unit,
// idex: registered ID/EX bus (master side).
module decode_stage
    import riscv_pkg::*;
#(
    parameter int P_DATA_WIDTH = 32,
    parameter int PC_WIDTH     = 9
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_flush_e,
    input  logic [P_DATA_WIDTH-1:0] i_instr_d,
    input  logic [PC_WIDTH:0]       i_pc_d,
    input  logic [PC_WIDTH:0]       i_pc4_d,
    input  logic                    i_regwrite_w,
    input  logic [4:0]              i_rd_w,
    input  logic [P_DATA_WIDTH-1:0] i_result_w,
    output logic [4:0]              o_rs1_d,
    output logic [4:0]              o_rs2_d,
    decode_stage_if.master          idex
);

    logic [6:0] opcode;
    logic [4:0] rd_d;
    logic [2:0] funct3_d;
    logic       funct7_b5;

    assign opcode    = i_instr_d[6:0];
    assign rd_d      = i_instr_d[11:7];
    assign funct3_d  = i_instr_d[14:12];
    assign o_rs1_d   = i_instr_d[19:15];
    assign o_rs2_d   = i_instr_d[24:20];
    assign funct7_b5 = i_instr_d[30];

    logic [P_DATA_WIDTH-1:0] rd1_d;
    logic [P_DATA_WIDTH-1:0] rd2_d;

    decode_stage_regfile #(
        .P_DATA_WIDTH(P_DATA_WIDTH)
    ) u_regfile (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .ra1     (o_rs1_d),
        .ra2     (o_rs2_d),
        .rd1     (rd1_d),
        .rd2     (rd2_d),
        .we      (i_regwrite_w),
        .wa      (i_rd_w),
        .wd      (i_result_w)
    );

    logic     regwrite_d;
    logic [1:0] resultsrc_d;
    logic     memwrite_d;
    logic     branch_d;
    logic     jump_d;
    logic     jalr_d;
    logic     alusrca_d;
    logic     alusrcb_d;
    alu_op_e  alucontrol_d;
    imm_fmt_e imm_fmt;
    logic     imm_en;

    always_comb begin
        regwrite_d   = 1'b0;
        resultsrc_d  = RES_ALU;
        memwrite_d   = 1'b0;
        branch_d     = 1'b0;
        jump_d       = 1'b0;
        jalr_d       = 1'b0;
        alusrca_d    = 1'b0;
        alusrcb_d    = 1'b0;
        alucontrol_d = ALU_ADD;
        imm_fmt      = IMM_I;
        imm_en       = 1'b0;
        case (opcode)
            OPC_OP: begin
                regwrite_d   = 1'b1;
                alucontrol_d = alu_from_funct(funct3_d, funct7_b5, 1'b1);
            end
            OPC_OPIMM: begin
                regwrite_d   = 1'b1;
                alusrcb_d    = 1'b1;
                alucontrol_d = alu_from_funct(funct3_d, funct7_b5, 1'b0);
                imm_en       = 1'b1;
            end
            OPC_LOAD: begin
                regwrite_d  = 1'b1;
                resultsrc_d = RES_MEM;
                alusrcb_d   = 1'b1;
                imm_en      = 1'b1;
            end
            OPC_STORE: begin
                memwrite_d = 1'b1;
                alusrcb_d  = 1'b1;
                imm_fmt    = IMM_S;
                imm_en     = 1'b1;
            end
            OPC_BRANCH: begin
                branch_d     = 1'b1;
                alucontrol_d = ALU_SUB;
                imm_fmt      = IMM_B;
                imm_en       = 1'b1;
            end
            OPC_JAL: begin
                regwrite_d  = 1'b1;
                resultsrc_d = RES_PC4;
                jump_d      = 1'b1;
                imm_fmt     = IMM_J;
                imm_en      = 1'b1;
            end
            OPC_JALR: begin
                regwrite_d  = 1'b1;
                resultsrc_d = RES_PC4;
                jump_d      = 1'b1;
                jalr_d      = 1'b1;
                alusrcb_d   = 1'b1;
                imm_en      = 1'b1;
            end
            OPC_LUI: begin
                regwrite_d   = 1'b1;
                alusrcb_d    = 1'b1;
                alucontrol_d = ALU_PASSB;
                imm_fmt      = IMM_U;
                imm_en       = 1'b1;
            end
            OPC_AUIPC: begin
                regwrite_d = 1'b1;
                alusrca_d  = 1'b1;
                alusrcb_d  = 1'b1;
                imm_fmt    = IMM_U;
                imm_en     = 1'b1;
            end
            default: ;
        endcase
    end

    logic [31:0] imm_d;

    // R-type and unrecognised opcodes carry no immediate; drive zero for them.
    always_comb begin
        imm_d = 32'd0;
        if (imm_en) begin
            case (imm_fmt)
                IMM_I:   imm_d = {{20{i_instr_d[31]}}, i_instr_d[31:20]};
                IMM_S:   imm_d = {{20{i_instr_d[31]}}, i_instr_d[31:25], i_instr_d[11:7]};
                IMM_B:   imm_d = {{20{i_instr_d[31]}}, i_instr_d[7], i_instr_d[30:25],
                                  i_instr_d[11:8], 1'b0};
                IMM_U:   imm_d = {i_instr_d[31:12], 12'd0};
                IMM_J:   imm_d = {{12{i_instr_d[31]}}, i_instr_d[19:12], i_instr_d[20],
                                  i_instr_d[30:21], 1'b0};
                default: imm_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n || i_flush_e) begin
            idex.rd1        <= '0;
            idex.rd2        <= '0;
            idex.imm        <= '0;
            idex.pc         <= '0;
            idex.pc4        <= '0;
            idex.rs1        <= '0;
            idex.rs2        <= '0;
            idex.rd         <= '0;
            idex.regwrite   <= 1'b0;
            idex.resultsrc  <= RES_ALU;
            idex.memwrite   <= 1'b0;
            idex.branch     <= 1'b0;
            idex.jump       <= 1'b0;
            idex.jalr       <= 1'b0;
            idex.alusrca    <= 1'b0;
            idex.alusrcb    <= 1'b0;
            idex.alucontrol <= ALU_ADD;
            idex.funct3     <= '0;
        end else begin
            idex.rd1        <= rd1_d;
            idex.rd2        <= rd2_d;
            idex.imm        <= imm_d;
            idex.pc         <= i_pc_d;
            idex.pc4        <= i_pc4_d;
            idex.rs1        <= o_rs1_d;
            idex.rs2        <= o_rs2_d;
            idex.rd         <= rd_d;
            idex.regwrite   <= regwrite_d;
            idex.resultsrc  <= resultsrc_d;
            idex.memwrite   <= memwrite_d;
            idex.branch     <= branch_d;
            idex.jump       <= jump_d;
            idex.jalr       <= jalr_d;
            idex.alusrca    <= alusrca_d;
            idex.alusrcb    <= alusrcb_d;
            idex.alucontrol <= alucontrol_d;
            idex.funct3     <= funct3_d;
        end
    end

endmodule
